// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if -- request/response bundle between the control unit and the
// multiply/divide unit.
//   start        : request an operation (ignored while busy)
//   op           : 0 = signed multiply, 1 = signed divide
//   a, b         : multiplicand/dividend and multiplier/divisor
//   busy         : operation in progress
//   done         : one-cycle pulse, hi/lo/flags valid
//   hi, lo       : mult product halves, or div remainder/quotient
//   div_by_zero  : pulses with done for a divide by zero
//   mult_ovf     : pulses with done when the product exceeds 32 signed bits
// master = control unit side, slave = muldiv_unit side.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;
    logic             mult_ovf;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo, div_by_zero, mult_ovf
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo, div_by_zero, mult_ovf
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit -- sequential signed multiply/divide, one bit per clock.
// Operands are converted to magnitudes on start, processed unsigned for
// WIDTH cycles (shift-add multiply or restoring divide), and sign-corrected
// in a final cycle that also registers hi/lo and the exception flags.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; clears all state
//   bus   : muldiv_unit_if.slave (start/op/a/b in; busy/done/hi/lo/flags out)
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam logic [5:0] LAST_COUNT = 6'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t stateReg, stateNext;

    logic               opReg;
    logic               aNegReg;
    logic               bNegReg;
    logic [WIDTH-1:0]   absAReg;
    logic [WIDTH-1:0]   absBReg;
    // mult: {partial product high, multiplier/product low}
    // div:  {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] accReg;
    logic [5:0]         countReg;
    logic [WIDTH-1:0]   hiReg;
    logic [WIDTH-1:0]   loReg;
    logic               doneReg;
    logic               divZeroReg;
    logic               multOvfReg;

    logic               acceptStart;
    logic               divZeroHit;

    // ---------------- next-state logic ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        acceptStart = 1'b0;
        divZeroHit  = 1'b0;
        case (stateReg)
            IDLE: begin
                if (bus.start) begin
                    // A zero divisor is answered immediately without iterating.
                    if (bus.op && (bus.b == '0)) begin
                        divZeroHit = 1'b1;
                    end else begin
                        acceptStart = 1'b1;
                        stateNext   = RUN;
                    end
                end
            end
            RUN: begin
                if (countReg == LAST_COUNT) begin
                    stateNext = FIX;
                end
            end
            FIX: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    logic [WIDTH-1:0]   absAIn;
    logic [WIDTH-1:0]   absBIn;
    logic [WIDTH:0]     multSum;
    logic [2*WIDTH-1:0] multStep;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divTrial;
    logic [2*WIDTH-1:0] divStep;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;
    logic               fixOvf;

    // Magnitude of the most negative value wraps back to itself, which is
    // exactly its unsigned magnitude.
    assign absAIn = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
    assign absBIn = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;

    // Shift-add: the carry out of the upper-half add becomes the new MSB.
    assign multSum  = {1'b0, accReg[2*WIDTH-1:WIDTH]}
                    + (accReg[0] ? {1'b0, absAReg} : {(WIDTH+1){1'b0}});
    assign multStep = {multSum, accReg[WIDTH-1:1]};

    // Restoring divide: the remainder is always below |b| <= 2^(WIDTH-1),
    // so the shifted value fits and bit WIDTH of the trial is its sign.
    assign divShift = {accReg[2*WIDTH-1:WIDTH], accReg[WIDTH-1]};
    assign divTrial = divShift - {1'b0, absBReg};
    assign divStep  = divTrial[WIDTH]
                    ? {divShift[WIDTH-1:0], accReg[WIDTH-2:0], 1'b0}
                    : {divTrial[WIDTH-1:0], accReg[WIDTH-2:0], 1'b1};

    assign product   = (aNegReg ^ bNegReg) ? (~accReg + 1'b1) : accReg;
    assign quotient  = (aNegReg ^ bNegReg) ? (~accReg[WIDTH-1:0] + 1'b1)
                                           : accReg[WIDTH-1:0];
    assign remainder = aNegReg ? (~accReg[2*WIDTH-1:WIDTH] + 1'b1)
                               : accReg[2*WIDTH-1:WIDTH];

    assign fixHi  = opReg ? remainder : product[2*WIDTH-1:WIDTH];
    assign fixLo  = opReg ? quotient  : product[WIDTH-1:0];
    assign fixOvf = !opReg
                  && (product[2*WIDTH-1:WIDTH] != {WIDTH{product[WIDTH-1]}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opReg      <= 1'b0;
            aNegReg    <= 1'b0;
            bNegReg    <= 1'b0;
            absAReg    <= '0;
            absBReg    <= '0;
            accReg     <= '0;
            countReg   <= '0;
            hiReg      <= '0;
            loReg      <= '0;
            doneReg    <= 1'b0;
            divZeroReg <= 1'b0;
            multOvfReg <= 1'b0;
        end else begin
            doneReg    <= 1'b0;
            divZeroReg <= 1'b0;
            multOvfReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (acceptStart) begin
                        opReg    <= bus.op;
                        aNegReg  <= bus.a[WIDTH-1];
                        bNegReg  <= bus.b[WIDTH-1];
                        absAReg  <= absAIn;
                        absBReg  <= absBIn;
                        countReg <= '0;
                        // mult iterates over the multiplier, div over the dividend
                        accReg   <= bus.op ? {{WIDTH{1'b0}}, absAIn}
                                           : {{WIDTH{1'b0}}, absBIn};
                    end else if (divZeroHit) begin
                        doneReg    <= 1'b1;
                        divZeroReg <= 1'b1;
                    end
                end
                RUN: begin
                    accReg   <= opReg ? divStep : multStep;
                    countReg <= countReg + 6'd1;
                end
                FIX: begin
                    hiReg      <= fixHi;
                    loReg      <= fixLo;
                    multOvfReg <= fixOvf;
                    doneReg    <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = (stateReg != IDLE);
    assign bus.done        = doneReg;
    assign bus.hi          = hiReg;
    assign bus.lo          = loReg;
    assign bus.div_by_zero = divZeroReg;
    assign bus.mult_ovf    = multOvfReg;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(32)) bus ();
    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;

    // Reference state: expected results of the most recent request.
    logic [31:0] expHi = '0;
    logic [31:0] expLo = '0;
    logic        expDbz = 1'b0;
    logic        expOvf = 1'b0;
    int          expLat = 34;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Plain signed 64-bit arithmetic; SV / and % truncate toward zero and
    // the remainder takes the dividend's sign.
    task automatic modelOp(input logic opIn, input logic [31:0] aIn, input logic [31:0] bIn);
        longint sa, sb, p, q, r;
        sa = longint'($signed(aIn));
        sb = longint'($signed(bIn));
        expDbz = 1'b0;
        expOvf = 1'b0;
        expLat = 34;
        if (!opIn) begin
            p = sa * sb;
            expHi  = p[63:32];
            expLo  = p[31:0];
            expOvf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (sb == 0) begin
            expDbz = 1'b1;
            expLat = 1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            expHi = r[31:0];
            expLo = q[31:0];
        end
    endtask

    task automatic startOp(input logic opIn, input logic [31:0] aIn, input logic [31:0] bIn);
        bus.op    = opIn;
        bus.a     = aIn;
        bus.b     = bIn;
        bus.start = 1'b1;
        modelOp(opIn, aIn, bIn);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Waits for done (bounded), optionally injecting a stray start at cycle
    // noiseAt, then checks latency, busy profile and results.
    task automatic waitResult(input string tag, input int noiseAt, input bit checkAfter);
        int lat, busyCnt;
        lat = 1;
        busyCnt = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busyCnt++;
            if (lat == noiseAt) begin
                bus.start = 1'b1;
                bus.op    = ~bus.op;
                bus.a     = $urandom;
                bus.b     = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        $display("op %s: lat=%0d hi=0x%08h lo=0x%08h dbz=%0b ovf=%0b", tag, lat,
                 bus.hi, bus.lo, bus.div_by_zero, bus.mult_ovf);
        checkVal({tag, " latency"}, 64'(lat), 64'(expLat));
        checkVal({tag, " busycycles"}, 64'(busyCnt), 64'(expLat == 1 ? 0 : 33));
        checkVal({tag, " busy@done"}, 64'(bus.busy), 64'(0));
        checkVal({tag, " hi"}, 64'(bus.hi), 64'(expHi));
        checkVal({tag, " lo"}, 64'(bus.lo), 64'(expLo));
        checkVal({tag, " dbz"}, 64'(bus.div_by_zero), 64'(expDbz));
        checkVal({tag, " ovf"}, 64'(bus.mult_ovf), 64'(expOvf));
        if (checkAfter) begin
            @(posedge clk); #1;
            checkVal({tag, " donepulse"}, 64'({bus.done, bus.div_by_zero, bus.mult_ovf}), 64'(0));
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0000_0000;
            3: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int doneSeen;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b0;
        #2;
        checkVal("reset busy", 64'(bus.busy), 64'(0));
        checkVal("reset done", 64'(bus.done), 64'(0));
        checkVal("reset hilo", {bus.hi, bus.lo}, 64'(0));
        checkVal("reset flags", 64'({bus.div_by_zero, bus.mult_ovf}), 64'(0));
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;

        startOp(1'b0, 32'd7, 32'hFFFF_FFFD);          waitResult("mult 7*-3", 0, 1);
        startOp(1'b0, 32'h0001_0000, 32'h0001_0000);  waitResult("mult 2^16*2^16", 0, 1);
        startOp(1'b0, 32'h8000_0000, 32'h8000_0000);  waitResult("mult min*min", 0, 1);
        startOp(1'b1, 32'hFFFF_FFF9, 32'd2);          waitResult("div -7/2", 0, 1);
        startOp(1'b1, 32'd7, 32'hFFFF_FFFE);          waitResult("div 7/-2", 0, 1);
        startOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);  waitResult("div min/-1", 0, 1);
        startOp(1'b1, 32'd5, 32'd0);                  waitResult("div 5/0", 0, 1);

        // Stray start mid-operation must not disturb the result.
        startOp(1'b0, 32'd12345, 32'hFFFF_FD5A);      waitResult("mult noise", 10, 1);

        // Reset in cycle 20 of an operation.
        startOp(1'b0, 32'h1234_5678, 32'h0000_0999);
        repeat (19) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        checkVal("abort busy", 64'(bus.busy), 64'(0));
        checkVal("abort hilo", {bus.hi, bus.lo}, 64'(0));
        checkVal("abort outs", 64'({bus.done, bus.div_by_zero, bus.mult_ovf}), 64'(0));
        doneSeen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) doneSeen++;
        end
        checkVal("abort quiet", 64'(doneSeen), 64'(0));
        #2 reset = 1'b1;
        expHi = '0;
        expLo = '0;
        @(posedge clk); #1;

        // Back-to-back: second start issued in the done cycle.
        startOp(1'b0, 32'd3, 32'd5);                  waitResult("b2b mult", 0, 0);
        startOp(1'b1, 32'd100, 32'd7);                waitResult("b2b div", 0, 1);

        for (int i = 0; i < 24; i++) begin
            logic        rOp;
            logic [31:0] rA, rB;
            rOp = 1'($urandom);
            rA  = pick();
            rB  = pick();
            startOp(rOp, rA, rB);
            waitResult($sformatf("rand%0d %s 0x%08h 0x%08h", i, rOp ? "div" : "mult", rA, rB),
                       ($urandom % 3 == 0) ? 5 : 0, 1'($urandom));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
